// File: rtl/usb_bag_pkg.sv
// Shared bag-type codes, FSM state encoding and response descriptor for the
// usb response scheduler.
package usb_bag_pkg;

  localparam int BAG_INIT   = 0;
  localparam int BAG_DIDX   = 5;
  localparam int BAG_DPARAM = 6;
  localparam int BAG_DDIDX  = 7;
  localparam int BAG_DLINK  = 8;
  localparam int BAG_DTYPE  = 9;
  localparam int BAG_DTEMP  = 10;
  localparam int BAG_DHEAD  = 11;
  localparam int BAG_DATA0  = 13;
  localparam int BAG_DATA1  = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GAP  = 3'd2,
    ST_DISP = 3'd3,
    ST_REST = 3'd4,
    ST_PRE  = 3'd5,
    ST_SEND = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  // Reply descriptor produced by the response map.
  // data: reply is a data bag (long turnaround, returns to REST afterwards).
  typedef struct packed {
    logic valid;
    logic data;
    logic sets_link;
    logic sets_stream;
  } resp_flags_t;

endpackage

// File: rtl/resp_map.sv
// Maps a received bag type onto the reply bag type and its reply attributes.
module resp_map
  import usb_bag_pkg::*;
#(
  parameter int BTW = 4
) (
  input  logic [BTW-1:0] btype,
  output logic [BTW-1:0] reply,
  output resp_flags_t    flags
);

  // Pure decode; unknown types produce no reply.
  always_comb begin
    reply = BTW'(BAG_INIT);
    flags = '0;
    case (btype)
      BTW'(BAG_DLINK): begin
        reply           = BTW'(BAG_DIDX);
        flags.valid     = 1'b1;
        flags.sets_link = 1'b1;
      end
      BTW'(BAG_DTYPE): begin
        reply       = BTW'(BAG_DPARAM);
        flags.valid = 1'b1;
      end
      BTW'(BAG_DTEMP): begin
        reply       = BTW'(BAG_DDIDX);
        flags.valid = 1'b1;
        flags.data  = 1'b1;
      end
      BTW'(BAG_DATA0), BTW'(BAG_DATA1): begin
        reply             = BTW'(BAG_DDIDX);
        flags.valid       = 1'b1;
        flags.data        = 1'b1;
        flags.sets_stream = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/usb_resp_sched.sv
// USB-link response scheduler: answers decoded host bags after a turnaround,
// emits periodic data bags while streaming, and guards the send handshake
// with a timeout.
//
// state | meaning
// IDLE  | after reset, drops link, moves straight to WAIT
// WAIT  | waiting for a received bag (fs_read)
// GAP   | acknowledging the read (fd_read=1) until fs_read falls
// DISP  | decode the captured bag type and pick the reply
// REST  | after a data reply: period timer for unsolicited bags, still accepts reads
// PRE   | turnaround wait before raising fs_send
// SEND  | fs_send held until fd_send or timeout
// ERR   | send timed out: err_tout pulse, link and streaming dropped
module usb_resp_sched
  import usb_bag_pkg::*;
#(
  parameter int BTW    = 4,
  parameter int CNW    = 16,
  parameter int CWAIT  = 48,
  parameter int DWAIT  = 80,
  parameter int PERIOD = 6250,
  parameter int TOUT   = 65535
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fs_read,
  input  logic [BTW-1:0] read_btype,
  output logic           fd_read,
  output logic           fs_send,
  output logic [BTW-1:0] send_btype,
  input  logic           fd_send,
  input  logic           stream_en,
  output logic           link,
  output logic           streaming,
  output logic           err_tout,
  output logic [15:0]    pkt_cnt
);

  localparam int CMAX = (CNW >= 31) ? 32'h7fff_ffff : ((1 << CNW) - 1);

  if (BTW < 4 || CNW < 1 || CNW > 31 ||
      CWAIT < 1 || CWAIT > CMAX || DWAIT < 1 || DWAIT > CMAX ||
      PERIOD < 1 || PERIOD > CMAX || TOUT < 1 || TOUT > CMAX) begin : g_bad_param
    $error("usb_resp_sched: parameter does not fit the counter width");
  end

  localparam logic [CNW-1:0] CWAIT_C  = CNW'(CWAIT);
  localparam logic [CNW-1:0] DWAIT_C  = CNW'(DWAIT);
  localparam logic [CNW-1:0] PER_LAST = CNW'(PERIOD - 1);
  localparam logic [CNW-1:0] TO_LAST  = CNW'(TOUT - 1);

  state_t           state;
  logic [CNW-1:0]   cnt;
  logic [CNW-1:0]   wait_len;
  logic             data_rep;
  logic [BTW-1:0]   btype_q;
  logic [BTW-1:0]   map_reply;
  resp_flags_t      map_flags;

  resp_map #(.BTW(BTW)) u_resp_map (
    .btype (btype_q),
    .reply (map_reply),
    .flags (map_flags)
  );

  // Scheduler FSM with its shared wait/period/timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wait_len   <= '0;
      data_rep   <= 1'b0;
      btype_q    <= '0;
      fd_read    <= 1'b0;
      fs_send    <= 1'b0;
      send_btype <= BTW'(BAG_INIT);
      link       <= 1'b0;
      streaming  <= 1'b0;
      err_tout   <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      err_tout <= 1'b0;
      case (state)
        ST_IDLE: begin
          link  <= 1'b0;
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fs_read) begin
            btype_q <= read_btype;
            fd_read <= 1'b1;
            cnt     <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Keep the latest type seen while the core still holds it valid.
          if (fs_read) begin
            btype_q <= read_btype;
          end else begin
            fd_read <= 1'b0;
            cnt     <= '0;
            state   <= ST_DISP;
          end
        end
        ST_DISP: begin
          cnt <= '0;
          if (map_flags.valid) begin
            send_btype <= map_reply;
            data_rep   <= map_flags.data;
            wait_len   <= map_flags.data ? DWAIT_C : CWAIT_C;
            if (map_flags.sets_link) begin
              link      <= 1'b1;
              streaming <= 1'b0;
            end
            if (map_flags.sets_stream) streaming <= 1'b1;
            state <= ST_PRE;
          end else begin
            state <= ST_REST;
          end
        end
        ST_PRE: begin
          if (cnt == wait_len - CNW'(1)) begin
            fs_send <= 1'b1;
            cnt     <= '0;
            state   <= ST_SEND;
          end else begin
            cnt <= cnt + CNW'(1);
          end
        end
        ST_SEND: begin
          // Completion beats a coincident timeout.
          if (fd_send) begin
            fs_send <= 1'b0;
            pkt_cnt <= pkt_cnt + 16'd1;
            cnt     <= '0;
            state   <= data_rep ? ST_REST : ST_WAIT;
          end else if (cnt == TO_LAST) begin
            fs_send   <= 1'b0;
            err_tout  <= 1'b1;
            link      <= 1'b0;
            streaming <= 1'b0;
            cnt       <= '0;
            state     <= ST_ERR;
          end else begin
            cnt <= cnt + CNW'(1);
          end
        end
        ST_ERR: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_REST: begin
          // Host traffic has priority over the unsolicited bag.
          if (fs_read) begin
            btype_q <= read_btype;
            fd_read <= 1'b1;
            cnt     <= '0;
            state   <= ST_GAP;
          end else if (cnt >= PER_LAST && link && streaming && stream_en) begin
            send_btype <= BTW'(BAG_DDIDX);
            data_rep   <= 1'b1;
            wait_len   <= DWAIT_C;
            cnt        <= '0;
            state      <= ST_PRE;
          end else if (cnt < PER_LAST) begin
            cnt <= cnt + CNW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
